decoder: RTL and testbench

- Inverse of the tokenizing encoder: reads token IDs from a token RAM, resolves each against a zero-terminated vocab RAM, and writes the reconstructed byte stream into an output RAM.
- Sits beside the encoder and drives three external sram instances (token, vocab, output) through explicit address/data ports.
- One decode run per cs request. The run ends on the end-of-stream token or on an error.

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/decoder_vocab_seek.sv | 53 +++++
 rtl/decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and token constants for the token decoder.
package decoder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T_ISSUE,
        ST_T_SAMPLE,
        ST_V_ISSUE,
        ST_V_SAMPLE,
        ST_C_ISSUE,
        ST_C_SAMPLE,
        ST_DONE,
        ST_ERR
    } decoder_state_e;

    // Token values at the default 8-bit token width.
    localparam logic [7:0] END_TOKEN = 8'h00;
    localparam logic [7:0] SEP_TOKEN = 8'hFF;

    // Byte that terminates every vocab entry (and the value written for separators).
    localparam logic [7:0] VOC_TERM  = 8'h00;

endpackage

// File: rtl/decoder_vocab_seek.sv
// Vocab entry locator: walks the vocab RAM counting zero terminators until the
// requested entry start is reached. The top level drives the RAM address from
// ptr and feeds each sampled byte back through step/voc_byte.
module vocab_seek
    import decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] index,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] voc_byte,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  found,
    output logic                  overflow
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [DATA_WIDTH-1:0] skip_q;
    logic [ADDR_WIDTH:0]   ptr_inc;
    logic                  skip_zero;
    logic                  byte_is_term;

    assign ptr_inc      = {1'b0, ptr_q} + (ADDR_WIDTH+1)'(1);
    assign skip_zero    = (skip_q == '0);
    assign byte_is_term = (voc_byte == DATA_WIDTH'(VOC_TERM));

    // With no entries left to skip, the current address is the entry start;
    // any other step must advance, and advancing past the top address is fatal.
    assign ptr      = ptr_q;
    assign found    = step && skip_zero;
    assign overflow = step && !skip_zero && ptr_inc[ADDR_WIDTH];

    // Scan pointer and remaining-terminator counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            skip_q <= '0;
        end else if (start) begin
            ptr_q  <= '0;
            skip_q <= index;
        end else if (step && !skip_zero && !ptr_inc[ADDR_WIDTH]) begin
            ptr_q <= ptr_inc[ADDR_WIDTH-1:0];
            if (byte_is_term) begin
                skip_q <= skip_q - DATA_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/decoder.sv
// Token decoder: fetches token IDs, locates each vocab entry and copies its
// bytes to the output RAM. All RAM addresses and write strobes are registered.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_IDLE     | waiting for cs; done/err hold the last run result
// ST_T_ISSUE  | present token pointer to the token RAM
// ST_T_SAMPLE | decode token: end, separator or vocab index
// ST_V_ISSUE  | present scan pointer to the vocab RAM
// ST_V_SAMPLE | step the entry locator with the sampled byte
// ST_C_ISSUE  | present copy pointer to the vocab RAM
// ST_C_SAMPLE | write a nonzero byte or finish the entry
// ST_DONE     | run complete, wait for cs low
// ST_ERR      | run aborted, wait for cs low
module decoder
    import decoder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEP_TOKEN  = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_dout,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_dout,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_we,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   out_count
);

    decoder_state_e state, next_state;

    logic [ADDR_WIDTH:0]   tok_ptr;
    logic [ADDR_WIDTH:0]   out_ptr;
    logic [ADDR_WIDTH-1:0] voc_ptr;
    logic [ADDR_WIDTH:0]   voc_inc;

    logic [ADDR_WIDTH-1:0] seek_ptr;
    logic                  seek_start;
    logic                  seek_step;
    logic                  seek_found;
    logic                  seek_ovf;

    logic                  out_full;
    logic                  voc_wrap;
    logic                  tok_is_end;
    logic                  tok_is_sep;
    logic                  voc_zero;

    logic                  run_start;
    logic                  wr_req;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  adv_tok;
    logic                  adv_out;
    logic                  adv_voc;

    assign voc_inc    = {1'b0, voc_ptr} + (ADDR_WIDTH+1)'(1);
    assign voc_wrap   = voc_inc[ADDR_WIDTH];
    assign out_full   = out_ptr[ADDR_WIDTH];
    assign tok_is_end = (tok_dout == DATA_WIDTH'(END_TOKEN));
    assign tok_is_sep = (tok_dout == SEP_TOKEN);
    assign voc_zero   = (voc_dout == DATA_WIDTH'(VOC_TERM));

    vocab_seek #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_seek (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (seek_start),
        .index    (tok_dout - DATA_WIDTH'(1)),
        .step     (seek_step),
        .voc_byte (voc_dout),
        .ptr      (seek_ptr),
        .found    (seek_found),
        .overflow (seek_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; every overflow path diverts to ST_ERR before writing.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:     if (cs) next_state = ST_T_ISSUE;
            ST_T_ISSUE:  next_state = tok_ptr[ADDR_WIDTH] ? ST_ERR : ST_T_SAMPLE;
            ST_T_SAMPLE: begin
                if (tok_is_end) begin
                    next_state = out_full ? ST_ERR : ST_DONE;
                end else if (tok_is_sep) begin
                    next_state = out_full ? ST_ERR : ST_T_ISSUE;
                end else begin
                    next_state = ST_V_ISSUE;
                end
            end
            ST_V_ISSUE:  next_state = ST_V_SAMPLE;
            ST_V_SAMPLE: begin
                if (seek_found) begin
                    next_state = ST_C_ISSUE;
                end else if (seek_ovf) begin
                    next_state = ST_ERR;
                end else begin
                    next_state = ST_V_ISSUE;
                end
            end
            ST_C_ISSUE:  next_state = ST_C_SAMPLE;
            ST_C_SAMPLE: begin
                if (voc_zero) begin
                    next_state = ST_T_ISSUE;
                end else if (out_full || voc_wrap) begin
                    next_state = ST_ERR;
                end else begin
                    next_state = ST_C_ISSUE;
                end
            end
            ST_DONE:     if (!cs) next_state = ST_IDLE;
            ST_ERR:      if (!cs) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Per-state actions: busy flag, write requests and pointer advances.
    always_comb begin
        busy       = 1'b0;
        run_start  = 1'b0;
        wr_req     = 1'b0;
        wr_data    = '0;
        adv_tok    = 1'b0;
        adv_out    = 1'b0;
        adv_voc    = 1'b0;
        seek_start = 1'b0;
        seek_step  = 1'b0;
        unique case (state)
            ST_IDLE:     run_start = cs;
            ST_T_ISSUE:  busy = 1'b1;
            ST_T_SAMPLE: begin
                busy = 1'b1;
                if (tok_is_end) begin
                    wr_req = !out_full;
                end else if (tok_is_sep) begin
                    wr_req  = !out_full;
                    adv_out = !out_full;
                    adv_tok = !out_full;
                end else begin
                    seek_start = 1'b1;
                end
            end
            ST_V_ISSUE:  busy = 1'b1;
            ST_V_SAMPLE: begin
                busy      = 1'b1;
                seek_step = 1'b1;
            end
            ST_C_ISSUE:  busy = 1'b1;
            ST_C_SAMPLE: begin
                busy = 1'b1;
                if (voc_zero) begin
                    adv_tok = 1'b1;
                end else if (!out_full && !voc_wrap) begin
                    wr_req  = 1'b1;
                    wr_data = voc_dout;
                    adv_out = 1'b1;
                    adv_voc = 1'b1;
                end
            end
            ST_DONE:     busy = 1'b0;
            ST_ERR:      busy = 1'b0;
            default:     busy = 1'b0;
        endcase
    end

    // Datapath: pointers, registered RAM ports, byte count and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_ptr   <= '0;
            out_ptr   <= '0;
            voc_ptr   <= '0;
            tok_addr  <= '0;
            voc_addr  <= '0;
            out_addr  <= '0;
            out_din   <= '0;
            out_we    <= 1'b0;
            out_count <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_we <= wr_req;
            if (wr_req) begin
                out_addr  <= out_ptr[ADDR_WIDTH-1:0];
                out_din   <= wr_data;
                out_count <= out_count + (ADDR_WIDTH+1)'(1);
            end
            if (run_start) begin
                tok_ptr   <= '0;
                out_ptr   <= '0;
                voc_ptr   <= '0;
                out_count <= '0;
                done      <= 1'b0;
                err       <= 1'b0;
            end
            if (state == ST_T_ISSUE) tok_addr <= tok_ptr[ADDR_WIDTH-1:0];
            if (state == ST_V_ISSUE) voc_addr <= seek_ptr;
            if (state == ST_C_ISSUE) voc_addr <= voc_ptr;
            if (seek_found) voc_ptr <= seek_ptr;
            if (adv_tok) tok_ptr <= tok_ptr + (ADDR_WIDTH+1)'(1);
            if (adv_out) out_ptr <= out_ptr + (ADDR_WIDTH+1)'(1);
            if (adv_voc) voc_ptr <= voc_inc[ADDR_WIDTH-1:0];
            if (next_state == ST_DONE && state != ST_DONE) begin
                done <= 1'b1;
            end
            if (next_state == ST_ERR && state != ST_ERR) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Bench for the token decoder: RAM models, a write scoreboard and a
// behavioural reference used for randomised token streams.
module tb_decoder;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0;
    logic [AW-1:0] tok_addr, voc_addr, out_addr;
    logic [DW-1:0] tok_dout, voc_dout, out_din;
    logic          out_we, busy, done, err;
    logic [AW:0]   out_count;

    logic [DW-1:0] tok_mem [DEPTH];
    logic [DW-1:0] voc_mem [DEPTH];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;
    int  n_checks = 0;
    int  n_errors = 0;

    decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .tok_addr  (tok_addr),
        .tok_dout  (tok_dout),
        .voc_addr  (voc_addr),
        .voc_dout  (voc_dout),
        .out_addr  (out_addr),
        .out_din   (out_din),
        .out_we    (out_we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    assign tok_dout = tok_mem[tok_addr];
    assign voc_dout = voc_mem[voc_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_we) begin
            check_val("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_w = exp_q.pop_front();
                check_val("write_addr", 32'(out_addr), 32'(mon_w.addr));
                check_val("write_data", 32'(out_din), 32'(mon_w.data));
            end
        end
    end

    task automatic push_wr(input int a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic clear_tokens();
        for (int i = 0; i < DEPTH; i++) tok_mem[i] = '0;
    endtask

    // Reference decode done as plain software loops over the RAM images.
    task automatic model_run(output int cnt, output bit e);
        int tp, op, a, k;
        logic [DW-1:0] t;
        tp = 0; op = 0; cnt = 0; e = 1'b0;
        while (1'b1) begin
            if (tp >= DEPTH) begin e = 1'b1; break; end
            t = tok_mem[tp];
            if (t == 8'h00) begin
                if (op >= DEPTH) e = 1'b1;
                else begin push_wr(op, 8'h00); cnt++; end
                break;
            end
            if (t == 8'hFF) begin
                if (op >= DEPTH) begin e = 1'b1; break; end
                push_wr(op, 8'h00); op++; cnt++; tp++;
                continue;
            end
            k = int'(t) - 1;
            a = 0;
            while (k > 0 && a < DEPTH) begin
                if (voc_mem[a] == 8'h00) k--;
                a++;
            end
            if (a >= DEPTH) begin e = 1'b1; break; end
            while (voc_mem[a] != 8'h00) begin
                if (op >= DEPTH || a == DEPTH - 1) begin e = 1'b1; break; end
                push_wr(op, voc_mem[a]); op++; cnt++; a++;
            end
            if (e) break;
            tp++;
        end
    endtask

    task automatic run_case(input string name, input int want_cnt, input bit want_err);
        bit seen;
        @(negedge clk); cs = 1'b1;
        @(negedge clk); cs = 1'b0;
        check_val({name, "_busy_start"}, 32'(busy), 1);
        check_val({name, "_done_cleared"}, 32'(done), 0);
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        #1;
        check_val({name, "_finished"}, 32'(seen), 1);
        check_val({name, "_err"}, 32'(err), 32'(want_err));
        check_val({name, "_busy_end"}, 32'(busy), 0);
        check_val({name, "_out_count"}, 32'(out_count), 32'(want_cnt));
        check_val({name, "_pending"}, 32'(exp_q.size()), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_val({name, "_done_held"}, 32'(done), 1);
    endtask

    initial begin
        int  rcnt;
        bit  rerr;
        int  len;
        bit  seen;
        logic [DW-1:0] picks [5];

        for (int i = 0; i < DEPTH; i++) voc_mem[i] = '0;
        voc_mem[0] = 8'h68; voc_mem[1] = 8'h69; voc_mem[2] = 8'h00;
        voc_mem[3] = 8'h79; voc_mem[4] = 8'h6F; voc_mem[5] = 8'h00;
        voc_mem[6] = 8'h61; voc_mem[7] = 8'h00;
        clear_tokens();

        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {3'b0, tok_addr, voc_addr, out_addr, out_din, out_we, busy, done, err, out_count}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tokens 2,1,0
        clear_tokens();
        tok_mem[0] = 8'd2; tok_mem[1] = 8'd1; tok_mem[2] = 8'd0;
        push_wr(0, 8'h79); push_wr(1, 8'h6F); push_wr(2, 8'h68); push_wr(3, 8'h69); push_wr(4, 8'h00);
        run_case("t210", 5, 1'b0);

        // Tokens 3,SEP,1,0
        clear_tokens();
        tok_mem[0] = 8'd3; tok_mem[1] = 8'hFF; tok_mem[2] = 8'd1; tok_mem[3] = 8'd0;
        push_wr(0, 8'h61); push_wr(1, 8'h00); push_wr(2, 8'h68); push_wr(3, 8'h69); push_wr(4, 8'h00);
        run_case("t3sep10", 5, 1'b0);

        // Empty entry at vocab address 8
        clear_tokens();
        tok_mem[0] = 8'd4;
        push_wr(0, 8'h00);
        run_case("t4_empty", 1, 1'b0);

        // Entry start would be address 16
        clear_tokens();
        tok_mem[0] = 8'd12;
        run_case("t12_vocab_ovf", 0, 1'b1);

        // Last address holds an empty entry
        clear_tokens();
        tok_mem[0] = 8'd11;
        push_wr(0, 8'h00);
        run_case("t11_edge", 1, 1'b0);

        // Output RAM fills after 8 copies of "hi"
        for (int i = 0; i < DEPTH; i++) tok_mem[i] = 8'd1;
        for (int i = 0; i < 8; i++) begin
            push_wr(2 * i, 8'h68);
            push_wr(2 * i + 1, 8'h69);
        end
        run_case("out_ovf", 16, 1'b1);

        // 16 empty-entry tokens, no terminator
        for (int i = 0; i < DEPTH; i++) tok_mem[i] = 8'd4;
        run_case("tok_wrap", 0, 1'b1);

        // Randomised streams checked against the reference model
        picks[0] = 8'd1; picks[1] = 8'd2; picks[2] = 8'd3; picks[3] = 8'd4; picks[4] = 8'hFF;
        for (int r = 0; r < 4; r++) begin
            clear_tokens();
            len = int'($urandom_range(0, 9));
            for (int i = 0; i < len; i++) tok_mem[i] = picks[$urandom_range(0, 4)];
            model_run(rcnt, rerr);
            run_case($sformatf("rand%0d", r), rcnt, rerr);
        end

        // Reset while copying
        clear_tokens();
        tok_mem[0] = 8'd1; tok_mem[1] = 8'd0;
        push_wr(0, 8'h68);
        @(negedge clk); cs = 1'b1;
        @(negedge clk); cs = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            #2;
            if (out_we) seen = 1'b1;
        end
        check_val("rst_reached_copy", 32'(seen), 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outputs",
                  {3'b0, tok_addr, voc_addr, out_addr, out_din, out_we, busy, done, err, out_count}, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_we) seen = 1'b1;
        end
        check_val("rst_no_write", 32'(seen), 0);
        exp_q.delete();
        rst_n = 1'b1;
        clear_tokens();
        tok_mem[0] = 8'd2; tok_mem[1] = 8'd1; tok_mem[2] = 8'd0;
        push_wr(0, 8'h79); push_wr(1, 8'h6F); push_wr(2, 8'h68); push_wr(3, 8'h69); push_wr(4, 8'h00);
        run_case("after_rst", 5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
